l1i_fetch_arbiter: RTL and testbench
====================================

Name: l1i_fetch_arbiter

Overview:
Sits between the frontend fetch requesters and the single L1I read port. It shares the port between branch-predictor demand misses (L0 miss path) and the next-line prefetcher, keeping at most one line request in flight. On a misprediction flush it squashes the outstanding request, so a stale line is never returned to a requester.

Parameters:
ADDR_WIDTH, 64, fetch address width in bits.
LINE_BYTES, 64, L1I line size in bytes; power of two; line offset bits = log2(LINE_BYTES).
STARVE_LIMIT, 4, consecutive prefetch losses before the prefetcher is force-granted; range 1..15.

Ports:
clk_in  input  1  clock.
rst_N_in  input  1  asynchronous active-low reset.
bp_req_valid  input  1  branch-predictor line request.
bp_req_addr  input  ADDR_WIDTH  demand fetch address; any alignment.
bp_req_ready  output  1  demand request accepted this cycle.
pf_req_valid  input  1  prefetcher line request.
pf_req_addr  input  ADDR_WIDTH  prefetch address; any alignment.
pf_req_ready  output  1  prefetch request accepted this cycle.
flush_in  input  1  misprediction redirect; squashes outstanding work.
l1i_req_valid  output  1  request to L1I.
l1i_req_addr  output  ADDR_WIDTH  line-aligned request address.
l1i_req_ready  input  1  L1I accepts the request.
l1i_resp_valid  input  1  L1I returns a line.
l1i_resp_data  input  LINE_BYTES*8  returned line.
bp_resp_valid  output  1  one-cycle pulse: line delivered to the branch predictor.
pf_resp_valid  output  1  one-cycle pulse: line delivered to the prefetcher.
resp_data  output  LINE_BYTES*8  registered line data, valid with either resp pulse.
busy  output  1  state is not IDLE.

Behaviour:
- Reset (asynchronous, rst_N_in low):
  - State goes to IDLE; the stale flag, owner and starvation counter clear.
  - All outputs are 0, including resp_data and l1i_req_addr.
  - Deassertion takes effect at the next clk_in edge.
- States:
  - IDLE: nothing outstanding.
  - ISSUE: l1i_req_valid held high.
  - INFLIGHT: request accepted, awaiting the line.
- IDLE arbitration (combinational ready):
  - bp_req_ready = IDLE & !flush_in & bp_req_valid & !force_pf.
  - pf_req_ready = IDLE & !flush_in & pf_req_valid & (force_pf | !bp_req_valid).
  - force_pf = (starve_cnt == STARVE_LIMIT).
- Handshake capture: on valid&ready, register the address with the low log2(LINE_BYTES) bits zeroed, register the owner (BP/PF), clear stale, and go to ISSUE. l1i_req_valid is high from the next cycle.
- Starvation counter:
  - In IDLE, increments (saturating at STARVE_LIMIT) when bp is granted while pf_req_valid is high.
  - Clears on a pf grant, or on any IDLE cycle with pf_req_valid low.
- ISSUE:
  - l1i_req_valid stays 1 with l1i_req_addr stable until l1i_req_ready; the request is never retracted, even on flush.
  - On l1i_req_ready: l1i_req_valid drops the next cycle and state goes to INFLIGHT.
- INFLIGHT, on l1i_resp_valid:
  - If not stale and flush_in is low: next cycle, resp_data = l1i_resp_data and the owner's resp_valid pulses for exactly one cycle.
  - Otherwise the line is discarded and no pulse is issued.
  - Either way, state returns to IDLE at that edge, so a new grant is possible in the same cycle as the resp pulse.
- flush_in:
  - In ISSUE or INFLIGHT: sets stale; the state sequence is otherwise unchanged.
  - In IDLE: only blocks grants that cycle.
  - flush_in and l1i_resp_valid in the same cycle: the line is discarded.
- l1i_resp_valid in IDLE or ISSUE (spurious, or the return of a request issued before reset) is ignored.
- resp_data holds its last value between pulses.
- busy = (state != IDLE), registered with the state.
- Throughput: at most one outstanding L1I request. Minimum loop is accept → ISSUE → INFLIGHT → response → pulse; IDLE is re-entered on the response edge.

Test Plan:
- Basic demand fetch: bp_req_valid with addr 0x1234 → bp_req_ready=1; next cycle l1i_req_valid=1, l1i_req_addr=0x1200. Then l1i_req_ready=1 → INFLIGHT. l1i_resp_valid with data D → bp_resp_valid=1 for one cycle with resp_data=D; pf_resp_valid stays 0.
- Priority and starvation (STARVE_LIMIT=4): bp_req_valid and pf_req_valid held high, each request completed → the first 4 grants go to bp and the 5th goes to pf. After that pf grant the counter is 0 and the next grant goes to bp.
- Backpressure: l1i_req_ready low for 3 cycles → l1i_req_valid stays 1 and l1i_req_addr stays constant; no new ready to either requester until IDLE is re-entered.
- Flush while INFLIGHT: flush_in pulsed, then l1i_resp_valid → no bp_resp_valid or pf_resp_valid; busy=0 next cycle. A new bp request at 0x2040 issues l1i_req_addr=0x2040.
- Flush coincident with response, and flush in IDLE: flush_in in the same cycle as l1i_resp_valid → line dropped. flush_in in IDLE with bp_req_valid=1 → bp_req_ready=0 that cycle and 1 the cycle after.
- Reset mid-operation: assert rst_N_in low while INFLIGHT → all outputs 0 immediately, without a clock edge. A later l1i_resp_valid → no resp pulse; busy stays 0.

Source files
------------

// File: rtl/l1i_fetch_arbiter.sv
// l1i_fetch_arbiter: shares the single L1I read port between branch-predictor
// demand misses and the next-line prefetcher, keeping at most one line
// request in flight and squashing it on a misprediction flush.
//
// Handshake semantics: a transfer happens on a clock edge where valid and
// ready are both high. On the requester side, ready is combinational and is
// only offered in IDLE. On the L1I side, l1i_req_valid is registered, is held
// with a stable address until l1i_req_ready, and is never retracted.
module l1i_fetch_arbiter #(
  parameter int ADDR_WIDTH   = 64,
  parameter int LINE_BYTES   = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_N_in,
  input  logic                    bp_req_valid,
  input  logic [ADDR_WIDTH-1:0]   bp_req_addr,
  output logic                    bp_req_ready,
  input  logic                    pf_req_valid,
  input  logic [ADDR_WIDTH-1:0]   pf_req_addr,
  output logic                    pf_req_ready,
  input  logic                    flush_in,
  output logic                    l1i_req_valid,
  output logic [ADDR_WIDTH-1:0]   l1i_req_addr,
  input  logic                    l1i_req_ready,
  input  logic                    l1i_resp_valid,
  input  logic [LINE_BYTES*8-1:0] l1i_resp_data,
  output logic                    bp_resp_valid,
  output logic                    pf_resp_valid,
  output logic [LINE_BYTES*8-1:0] resp_data,
  output logic                    busy,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    INFLIGHT = 2'd2
  } state_t;

  // Low line-offset bits, cleared when a request address is captured.
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic [3:0]            STARVE_MAX  = 4'(STARVE_LIMIT);

  state_t                  state_q, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    owner_q;      // 0: branch predictor, 1: prefetcher
  logic                    stale_q;
  logic [3:0]              starve_q;
  logic                    bp_resp_q, pf_resp_q;
  logic [LINE_BYTES*8-1:0] resp_data_q;

  logic force_pf;
  logic grant_bp, grant_pf;
  logic set_stale;
  logic deliver;

  assign force_pf = (starve_q == STARVE_MAX);

  // Next-state, grant and delivery decisions; defaults first.
  always_comb begin
    state_nxt = state_q;
    grant_bp  = 1'b0;
    grant_pf  = 1'b0;
    set_stale = 1'b0;
    deliver   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_N_in && !flush_in) begin
          grant_bp = bp_req_valid & ~force_pf;
          grant_pf = pf_req_valid & (force_pf | ~bp_req_valid);
          if (grant_bp || grant_pf) state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        set_stale = flush_in;
        if (l1i_req_ready) state_nxt = INFLIGHT;
      end
      INFLIGHT: begin
        set_stale = flush_in;
        if (l1i_resp_valid) begin
          state_nxt = IDLE;
          deliver   = ~stale_q & ~flush_in;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) state_q <= IDLE;
    else           state_q <= state_nxt;
  end

  // Request capture (address, owner) and the stale flag for squashed work.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      addr_q  <= '0;
      owner_q <= 1'b0;
      stale_q <= 1'b0;
    end else if (grant_bp || grant_pf) begin
      addr_q  <= (grant_bp ? bp_req_addr : pf_req_addr) & ~OFFSET_MASK;
      owner_q <= grant_pf;
      stale_q <= 1'b0;
    end else if (set_stale) begin
      stale_q <= 1'b1;
    end
  end

  // Count consecutive prefetch losses; only IDLE cycles move the counter.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      starve_q <= '0;
    end else if (state_q == IDLE) begin
      if (grant_pf || !pf_req_valid)             starve_q <= '0;
      else if (grant_bp && starve_q != STARVE_MAX) starve_q <= starve_q + 4'd1;
    end
  end

  // Registered response: one-cycle pulse to the owner, data held between pulses.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      bp_resp_q   <= 1'b0;
      pf_resp_q   <= 1'b0;
      resp_data_q <= '0;
    end else begin
      bp_resp_q <= deliver & ~owner_q;
      pf_resp_q <= deliver & owner_q;
      if (deliver) resp_data_q <= l1i_resp_data;
    end
  end

  assign bp_req_ready  = grant_bp;
  assign pf_req_ready  = grant_pf;
  assign l1i_req_valid = (state_q == ISSUE);
  assign l1i_req_addr  = addr_q;
  assign bp_resp_valid = bp_resp_q;
  assign pf_resp_valid = pf_resp_q;
  assign resp_data     = resp_data_q;
  assign busy          = (state_q != IDLE);
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_l1i_fetch_arbiter.sv
// Bench for l1i_fetch_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level reference model and a response
// scoreboard drained by an independent monitor.
module tb_l1i_fetch_arbiter;

  localparam int AW  = 64;
  localparam int LB  = 64;
  localparam int DW  = LB * 8;
  localparam int LIM = 4;
  localparam int W   = DW + 1;   // {owner, line}

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic rst_N_in;
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          bp_req_valid, pf_req_valid, flush_in;
  logic [AW-1:0] bp_req_addr, pf_req_addr;
  logic          bp_req_ready, pf_req_ready;
  logic          l1i_req_valid, l1i_req_ready, l1i_resp_valid;
  logic [AW-1:0] l1i_req_addr;
  logic [DW-1:0] l1i_resp_data, resp_data;
  logic          bp_resp_valid, pf_resp_valid, busy;
  logic [1:0]    state_dbg;

  l1i_fetch_arbiter #(.ADDR_WIDTH(AW), .LINE_BYTES(LB), .STARVE_LIMIT(LIM)) dut (
    .clk_in(clk_in), .rst_N_in(rst_N_in),
    .bp_req_valid(bp_req_valid), .bp_req_addr(bp_req_addr), .bp_req_ready(bp_req_ready),
    .pf_req_valid(pf_req_valid), .pf_req_addr(pf_req_addr), .pf_req_ready(pf_req_ready),
    .flush_in(flush_in),
    .l1i_req_valid(l1i_req_valid), .l1i_req_addr(l1i_req_addr), .l1i_req_ready(l1i_req_ready),
    .l1i_resp_valid(l1i_resp_valid), .l1i_resp_data(l1i_resp_data),
    .bp_resp_valid(bp_resp_valid), .pf_resp_valid(pf_resp_valid), .resp_data(resp_data),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- counters / scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  int           exp_cyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 nothing outstanding, 1 request offered to L1I, 2 awaiting line
  int            m_phase;
  int            m_losses;
  logic [AW-1:0] m_addr;
  logic          m_owner, m_stale;
  logic          samp_bp_rdy, samp_pf_rdy;

  task automatic model_reset();
    m_phase = 0; m_losses = 0; m_addr = '0; m_owner = 1'b0; m_stale = 1'b0;
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input logic bpv, input logic [AW-1:0] bpa,
                      input logic pfv, input logic [AW-1:0] pfa,
                      input logic fl, input logic rdy, input logic rv);
    logic [DW-1:0] d;
    logic bg, pg, fp;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
    bp_req_valid = bpv; bp_req_addr = bpa;
    pf_req_valid = pfv; pf_req_addr = pfa;
    flush_in = fl; l1i_req_ready = rdy; l1i_resp_valid = rv; l1i_resp_data = d;
    @(negedge clk_in);
    bg = 1'b0; pg = 1'b0;
    if (m_phase == 0 && !fl) begin
      fp = (m_losses == LIM);
      bg = bpv && !fp;
      pg = pfv && (fp || !bpv);
    end
    chk("bp_req_ready", bp_req_ready, bg);
    chk("pf_req_ready", pf_req_ready, pg);
    chk("l1i_req_valid", l1i_req_valid, m_phase == 1);
    chk("l1i_req_addr", l1i_req_addr, m_addr);
    chk("busy", busy, m_phase != 0);
    samp_bp_rdy = bp_req_ready;
    samp_pf_rdy = pf_req_ready;
    case (m_phase)
      0: begin
        if (bg || pg) begin
          m_addr  = ((bg ? bpa : pfa) / LB) * LB;
          m_owner = pg;
          m_stale = 1'b0;
          m_phase = 1;
        end
        if (pg || !pfv)  m_losses = 0;
        else if (bg)     m_losses = (m_losses < LIM) ? m_losses + 1 : LIM;
      end
      1: begin
        if (fl)  m_stale = 1'b1;
        if (rdy) m_phase = 2;
      end
      default: begin
        if (fl) m_stale = 1'b1;
        if (rv) begin
          if (!m_stale && !fl) begin
            exp_q.push_back({m_owner, d});
            exp_cyc.push_back(cyc);
          end
          m_phase = 0;
        end
      end
    endcase
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- response monitor ----------------
  logic [DW-1:0] last_data = '0;
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk_in);
      if (!rst_N_in) begin
        chk("rst_bp_resp_valid", bp_resp_valid, 0);
        chk("rst_pf_resp_valid", pf_resp_valid, 0);
        last_data = '0;
        exp_q.delete();
        exp_cyc.delete();
      end else if (bp_resp_valid || pf_resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp_pulse", {bp_resp_valid, pf_resp_valid}, 0);
        end else begin
          e = exp_q.pop_front();
          void'(exp_cyc.pop_front());
          chk("resp_to_bp", bp_resp_valid, !e[W-1]);
          chk("resp_to_pf", pf_resp_valid, e[W-1]);
          chk_data("resp_data", resp_data, e[DW-1:0]);
          last_data = e[DW-1:0];
        end
      end else begin
        if (exp_q.size() != 0 && exp_cyc[0] < cyc) begin
          chk("missing_resp_pulse", 0, 1);
          void'(exp_q.pop_front());
          void'(exp_cyc.pop_front());
        end
        chk_data("resp_data_hold", resp_data, last_data);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] seq;
    rst_N_in = 1'b0;
    bp_req_valid = 0; pf_req_valid = 0; flush_in = 0;
    l1i_req_ready = 0; l1i_resp_valid = 0;
    bp_req_addr = '0; pf_req_addr = '0; l1i_resp_data = '0;
    model_reset();
    #12;
    chk("reset_l1i_req_valid", l1i_req_valid, 0);
    chk("reset_l1i_req_addr", l1i_req_addr, 0);
    chk("reset_bp_req_ready", bp_req_ready, 0);
    chk("reset_pf_req_ready", pf_req_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_state_dbg", state_dbg, 0);
    chk_data("reset_resp_data", resp_data, '0);
    @(posedge clk_in); #1;
    rst_N_in = 1'b1;

    // Basic demand fetch.
    step(1, 64'h1234, 0, '0, 0, 0, 0);
    chk("basic_grant", samp_bp_rdy, 1);
    chk("basic_addr", l1i_req_addr, 64'h1200);
    chk("basic_req_valid", l1i_req_valid, 1);
    step(0, '0, 0, '0, 0, 1, 0);
    step(0, '0, 0, '0, 0, 0, 1);
    idle(2);

    // Priority and starvation: both requesters held high.
    seq = '0;
    for (int k = 0; k < 6; k++) begin
      step(1, 64'h1000 + 64'(k), 1, 64'h8000 + 64'(k), 0, 0, 0);
      seq[k] = samp_pf_rdy;
      step(1, 64'h1000, 1, 64'h8000, 0, 1, 0);
      step(1, 64'h1000, 1, 64'h8000, 0, 0, 1);
    end
    chk("starve_grant_sequence", seq, 6'b010000);
    idle(2);

    // Backpressure: L1I not ready for three cycles.
    step(1, 64'h3333, 0, '0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(1, 64'h4444, 1, 64'h5555, 0, 0, 0);
    chk("bp_stall_addr", l1i_req_addr, 64'h3300);
    step(1, 64'h4444, 1, 64'h5555, 0, 1, 0);
    step(0, '0, 0, '0, 0, 0, 1);
    idle(2);

    // Flush while INFLIGHT, then a fresh request.
    step(1, 64'h7777, 0, '0, 0, 0, 0);
    step(0, '0, 0, '0, 0, 1, 0);
    step(0, '0, 0, '0, 1, 0, 0);
    step(0, '0, 0, '0, 0, 0, 1);
    step(1, 64'h2040, 0, '0, 0, 0, 0);
    chk("post_flush_addr", l1i_req_addr, 64'h2040);
    step(0, '0, 0, '0, 0, 1, 0);
    step(0, '0, 0, '0, 0, 0, 1);
    idle(2);

    // Flush coincident with the response, then flush in IDLE.
    step(0, '0, 1, 64'h9abc, 0, 0, 0);
    step(0, '0, 0, '0, 0, 1, 0);
    step(0, '0, 0, '0, 1, 0, 1);
    step(1, 64'h6000, 0, '0, 1, 0, 0);
    chk("idle_flush_blocks", samp_bp_rdy, 0);
    step(1, 64'h6000, 0, '0, 0, 0, 0);
    chk("idle_flush_released", samp_bp_rdy, 1);
    step(0, '0, 0, '0, 0, 1, 0);
    step(0, '0, 0, '0, 0, 0, 1);
    idle(2);

    // Reset mid-operation while INFLIGHT.
    step(1, 64'habc0, 0, '0, 0, 0, 0);
    step(0, '0, 0, '0, 0, 1, 0);
    bp_req_valid = 1; pf_req_valid = 1;
    #2 rst_N_in = 1'b0;
    #1;
    chk("async_rst_l1i_req_valid", l1i_req_valid, 0);
    chk("async_rst_l1i_req_addr", l1i_req_addr, 0);
    chk("async_rst_bp_req_ready", bp_req_ready, 0);
    chk("async_rst_pf_req_ready", pf_req_ready, 0);
    chk("async_rst_busy", busy, 0);
    chk_data("async_rst_resp_data", resp_data, '0);
    bp_req_valid = 0; pf_req_valid = 0; l1i_req_ready = 0;
    @(posedge clk_in); @(posedge clk_in); #1;
    rst_N_in = 1'b1;
    model_reset();
    step(0, '0, 0, '0, 0, 0, 1);
    idle(2);

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      step($urandom_range(0, 9) < 6, {$urandom(), $urandom()},
           $urandom_range(0, 9) < 6, {$urandom(), $urandom()},
           $urandom_range(0, 99) < 8, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) < 4);
    end

    // Drain anything outstanding and let the monitor see the last pulse.
    for (int k = 0; k < 4; k++) step(0, '0, 0, '0, 0, 1, 1);
    idle(2);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
